// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: widths, instruction classes and ROB entry payload.
package tomasulo_pkg;

    localparam int unsigned TAG_W         = 6;
    localparam int unsigned DATA_W        = 6;
    localparam int unsigned REG_W         = 4;
    localparam int unsigned TYPE_W        = 3;
    localparam int unsigned NUM_ARCH_REGS = 10;

    typedef enum logic [TYPE_W-1:0] {
        CLS_ADD = 3'd0,
        CLS_SUB = 3'd1,
        CLS_MUL = 3'd2,
        CLS_DIV = 3'd3,
        CLS_LD  = 3'd4,
        CLS_ST  = 3'd5
    } instr_class_e;

    // Tag 0 means the operand lives in the architectural register file.
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [TYPE_W-1:0] itype;
        logic [REG_W-1:0]  dest_reg;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ROB index pointer: counts 0..DEPTH-1 on inc, cleared by flush or reset.
module rob_ptr #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Pointer register with wrap at DEPTH-1; flush has priority over inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (flush) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/rob_dispatch_buffer.sv
// Reorder buffer write side: in-order tag allocation, writeback capture by tag,
// and oldest-completed-entry presentation to the commit stage.
module rob_dispatch_buffer
    import tomasulo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [TYPE_W-1:0] issue_type,
    input  logic [REG_W-1:0]  issue_reg,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_err,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_reg,
    output logic [TYPE_W-1:0] commit_type,
    output logic [DATA_W-1:0] commit_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    rob_entry_t       entries [DEPTH];
    rob_entry_t       head_e;
    logic             alloc;
    logic             pop;
    logic             wb_in_range;
    logic             wb_ok;
    logic [PTR_W-1:0] wb_idx;

    rob_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_ptr (
        .clk   (clk1),
        .rst_n (rst_n),
        .flush (flush),
        .inc   (pop),
        .ptr   (head)
    );

    rob_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_ptr (
        .clk   (clk1),
        .rst_n (rst_n),
        .flush (flush),
        .inc   (alloc),
        .ptr   (tail)
    );

    // Handshake decode, writeback legality and head presentation from registered state.
    always_comb begin
        head_e       = entries[head];
        full         = (count == CNT_W'(DEPTH));
        empty        = (count == '0);
        issue_ready  = !full;
        issue_tag    = TAG_W'(tail) + TAG_W'(1);
        commit_valid = head_e.busy && head_e.done;
        commit_tag   = TAG_W'(head) + TAG_W'(1);
        commit_reg   = head_e.dest_reg;
        commit_type  = head_e.itype;
        commit_data  = head_e.data;
        alloc        = issue_valid && issue_ready && !flush;
        pop          = commit_valid && commit_ready && !flush;
        wb_in_range  = (wb_tag != TAG_NONE) && (wb_tag <= TAG_W'(DEPTH));
        wb_idx       = PTR_W'(wb_tag - TAG_W'(1));
        wb_ok        = wb_valid && wb_in_range && entries[wb_idx].busy;
    end

    // Entry array: pop clears head, alloc fills tail, legal writeback marks done.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (pop && (PTR_W'(i) == head)) begin
                    entries[i] <= '0;
                end else if (alloc && (PTR_W'(i) == tail)) begin
                    entries[i] <= '{busy: 1'b1, done: 1'b0, itype: issue_type,
                                    dest_reg: issue_reg, data: '0};
                end else if (wb_ok && (PTR_W'(i) == wb_idx)) begin
                    entries[i].done <= 1'b1;
                    entries[i].data <= wb_data;
                end
            end
        end
    end

    // Occupancy counter and one-cycle illegal-writeback pulse.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wb_err <= 1'b0;
        end else if (flush) begin
            count  <= '0;
            wb_err <= 1'b0;
        end else begin
            count  <= count + CNT_W'(alloc) - CNT_W'(pop);
            wb_err <= wb_valid && !wb_ok;
        end
    end

endmodule

// File: tb/tb_rob_dispatch_buffer.sv
// Self-checking bench for rob_dispatch_buffer: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_rob_dispatch_buffer;
    import tomasulo_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              issue_valid;
    logic              issue_ready;
    logic [TYPE_W-1:0] issue_type;
    logic [REG_W-1:0]  issue_reg;
    logic [TAG_W-1:0]  issue_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              wb_err;
    logic              commit_valid;
    logic              commit_ready;
    logic [TAG_W-1:0]  commit_tag;
    logic [REG_W-1:0]  commit_reg;
    logic [TYPE_W-1:0] commit_type;
    logic [DATA_W-1:0] commit_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    always #5 clk1 = ~clk1;

    rob_dispatch_buffer #(.DEPTH(DEPTH)) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_type   (issue_type),
        .issue_reg    (issue_reg),
        .issue_tag    (issue_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .wb_err       (wb_err),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_tag   (commit_tag),
        .commit_reg   (commit_reg),
        .commit_type  (commit_type),
        .commit_data  (commit_data),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    // Reference model: program-ordered queue of in-flight instructions.
    typedef struct {
        int tag;
        int itype;
        int rd;
        bit done;
        int data;
    } m_entry_t;

    m_entry_t mq[$];
    int       m_next_tag;
    bit       m_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit iv; int it; int ir; bit wv; int wt; int wd; bit cr;
        int e_count; bit e_cv; int e_ctag; int e_creg; int e_cdata; bit e_err; int e_itag;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_next_tag = 1;
        m_err      = 1'b0;
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("m_count", 32'(count), sz);
        chk("m_empty", 32'(empty), 32'(sz == 0));
        chk("m_full", 32'(full), 32'(sz == DEPTH));
        chk("m_issue_ready", 32'(issue_ready), 32'(sz < DEPTH));
        chk("m_issue_tag", 32'(issue_tag), m_next_tag);
        chk("m_wb_err", 32'(wb_err), 32'(m_err));
        if (sz > 0) begin
            chk("m_commit_valid", 32'(commit_valid), 32'(mq[0].done));
            chk("m_commit_tag", 32'(commit_tag), mq[0].tag);
            chk("m_commit_reg", 32'(commit_reg), mq[0].rd);
            chk("m_commit_type", 32'(commit_type), mq[0].itype);
            chk("m_commit_data", 32'(commit_data), mq[0].data);
        end else begin
            chk("m_commit_valid", 32'(commit_valid), 0);
            chk("m_commit_tag", 32'(commit_tag), m_next_tag);
            chk("m_commit_reg", 32'(commit_reg), 0);
            chk("m_commit_type", 32'(commit_type), 0);
            chk("m_commit_data", 32'(commit_data), 0);
        end
    endtask

    // Drive one cycle of inputs, check model before the edge, advance the model across it.
    task automatic step(input bit iv, input int it, input int ir, input bit wv, input int wt,
                        input int wd, input bit cr, input bit fl);
        bit       do_alloc;
        bit       do_pop;
        int       k;
        m_entry_t e;
        issue_valid  = iv;
        issue_type   = TYPE_W'(it);
        issue_reg    = REG_W'(ir);
        wb_valid     = wv;
        wb_tag       = TAG_W'(wt);
        wb_data      = DATA_W'(wd);
        commit_ready = cr;
        flush        = fl;
        #1;
        check_model();
        if (fl) begin
            model_reset();
        end else begin
            do_alloc = iv && (mq.size() < DEPTH);
            do_pop   = cr && (mq.size() > 0) && mq[0].done;
            k = -1;
            for (int j = 0; j < mq.size(); j++) begin
                if (mq[j].tag == wt) k = j;
            end
            m_err = wv && (k < 0);
            if (wv && k >= 0) begin
                e = mq[k];
                e.done = 1'b1;
                e.data = wd;
                mq[k] = e;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_alloc) begin
                e = '{tag: m_next_tag, itype: it, rd: ir, done: 1'b0, data: 0};
                mq.push_back(e);
                m_next_tag = (m_next_tag == DEPTH) ? 1 : m_next_tag + 1;
            end
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_type   = '0;
        issue_reg    = '0;
        wb_valid     = 1'b0;
        wb_tag       = '0;
        wb_data      = '0;
        commit_ready = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        int wt;
        int sz;

        // Directed sequence: three issues, out-of-order writeback, in-order commit, illegal writebacks.
        //            iv  it                 ir  wv wt wd     cr  cnt cv ctag creg cdata err itag
        vecs[0]  = '{1, int'(CLS_ADD), 2,  0, 0, 0,     0,  1,  0, 1,   2,   0,    0,  2};
        vecs[1]  = '{1, int'(CLS_SUB), 5,  0, 0, 0,     0,  2,  0, 1,   2,   0,    0,  3};
        vecs[2]  = '{1, int'(CLS_MUL), 7,  0, 0, 0,     0,  3,  0, 1,   2,   0,    0,  4};
        vecs[3]  = '{0, 0,             0,  1, 2, 'h15,  0,  3,  0, 1,   2,   0,    0,  4};
        vecs[4]  = '{0, 0,             0,  1, 1, 'h0A,  0,  3,  1, 1,   2,   'h0A, 0,  4};
        vecs[5]  = '{0, 0,             0,  0, 0, 0,     1,  2,  1, 2,   5,   'h15, 0,  4};
        vecs[6]  = '{0, 0,             0,  0, 0, 0,     1,  1,  0, 3,   7,   0,    0,  4};
        vecs[7]  = '{0, 0,             0,  0, 0, 0,     1,  1,  0, 3,   7,   0,    0,  4};
        vecs[8]  = '{0, 0,             0,  1, 0, 1,     0,  1,  0, 3,   7,   0,    1,  4};
        vecs[9]  = '{0, 0,             0,  0, 0, 0,     0,  1,  0, 3,   7,   0,    0,  4};
        vecs[10] = '{0, 0,             0,  1, 9, 2,     0,  1,  0, 3,   7,   0,    1,  4};
        vecs[11] = '{0, 0,             0,  1, 2, 3,     0,  1,  0, 3,   7,   0,    1,  4};
        vecs[12] = '{0, 0,             0,  1, 3, 'h3F,  0,  1,  1, 3,   7,   'h3F, 0,  4};
        vecs[13] = '{0, 0,             0,  0, 0, 0,     1,  0,  0, 4,   0,   0,    0,  4};

        // Reset
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_issue_ready", 32'(issue_ready), 1);
        chk("rst_issue_tag", 32'(issue_tag), 1);
        chk("rst_commit_valid", 32'(commit_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_commit_data", 32'(commit_data), 0);
        chk("rst_wb_err", 32'(wb_err), 0);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].iv, vecs[i].it, vecs[i].ir, vecs[i].wv, vecs[i].wt, vecs[i].wd,
                 vecs[i].cr, 1'b0);
            chk($sformatf("vec%0d_count", i), 32'(count), vecs[i].e_count);
            chk($sformatf("vec%0d_commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
            chk($sformatf("vec%0d_commit_tag", i), 32'(commit_tag), vecs[i].e_ctag);
            chk($sformatf("vec%0d_commit_reg", i), 32'(commit_reg), vecs[i].e_creg);
            chk($sformatf("vec%0d_commit_data", i), 32'(commit_data), vecs[i].e_cdata);
            chk($sformatf("vec%0d_wb_err", i), 32'(wb_err), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d_issue_tag", i), 32'(issue_tag), vecs[i].e_itag);
        end

        // Fill to full, then alloc+pop in the same cycle while full.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("fill_start_tag", 32'(issue_tag), 1);
        for (int i = 0; i < 8; i++) step(1, int'(CLS_LD), i, 0, 0, 0, 0, 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_issue_ready", 32'(issue_ready), 0);
        chk("fill_count", 32'(count), 8);
        step(0, 0, 0, 1, 1, 5, 0, 0);
        chk("fill_head_done", 32'(commit_valid), 1);
        step(1, int'(CLS_ST), 9, 0, 0, 0, 1, 0);
        chk("full_pop_count", 32'(count), 7);
        chk("full_pop_tag_wrap", 32'(issue_tag), 1);
        chk("full_pop_head", 32'(commit_tag), 2);
        step(1, int'(CLS_ST), 9, 0, 0, 0, 0, 0);
        chk("wrap_alloc_count", 32'(count), 8);
        chk("wrap_alloc_next_tag", 32'(issue_tag), 2);

        // Flush with five entries (two done) and commit_ready asserted.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, int'(CLS_ADD), i + 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 'h11, 0, 0);
        step(0, 0, 0, 1, 2, 'h22, 0, 0);
        chk("pre_flush_count", 32'(count), 5);
        chk("pre_flush_cv", 32'(commit_valid), 1);
        step(1, int'(CLS_ADD), 3, 1, 3, 'h33, 1, 1);
        chk("flush_count", 32'(count), 0);
        chk("flush_cv", 32'(commit_valid), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_issue_tag", 32'(issue_tag), 1);
        chk("flush_wb_err", 32'(wb_err), 0);
        step(1, int'(CLS_DIV), 4, 0, 0, 0, 0, 0);
        chk("post_flush_head_tag", 32'(commit_tag), 1);
        chk("post_flush_count", 32'(count), 1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) step(1, int'(CLS_MUL), i, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 7, 0, 0);
        chk("burst_count", 32'(count), 4);
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_issue_tag", 32'(issue_tag), 1);
        chk("arst_commit_valid", 32'(commit_valid), 0);
        chk("arst_issue_ready", 32'(issue_ready), 1);
        chk("arst_commit_tag", 32'(commit_tag), 1);
        model_reset();
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            sz = mq.size();
            if (sz > 0 && $urandom_range(0, 9) < 7) wt = mq[$urandom_range(0, sz - 1)].tag;
            else wt = int'($urandom_range(0, 10));
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, 5)),
                 int'($urandom_range(0, NUM_ARCH_REGS - 1)),
                 $urandom_range(0, 1) == 1, wt, int'($urandom_range(0, 63)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
        end
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
